// File: rtl/tt_pkg.sv
// Shared types and defaults for the truth-table response checker.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int TT_NVARS  = 3;
  localparam int TT_NFUNC  = 6;
  localparam int TT_ROWS   = 1 << TT_NVARS;
  localparam int TT_IDLE_W = 8;

  // f0..f5 from LSB: 1F, 20, 04, 8A, 2A, CE
  localparam logic [TT_NFUNC*TT_ROWS-1:0] TT_EXPECTED = 48'hCE2A8A04201F;

endpackage

// File: rtl/tt_popcount.sv
// Combinational population count of a bit vector.
module tt_popcount #(
  parameter int WIDTH = 48,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Collects one sample per truth-table row, then compares the captured tables
// against golden masks and reports per-function pass/fail and error flags.
module truth_table_checker
  import tt_pkg::*;
#(
  parameter int NVARS = TT_NVARS,
  parameter int NFUNC = TT_NFUNC,
  parameter logic [NFUNC*(1<<NVARS)-1:0] EXPECTED = TT_EXPECTED,
  parameter int TIMEOUT = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [NVARS-1:0]                          in_row,
  input  logic [NFUNC-1:0]                          in_funcs,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      pass,
  output logic [NFUNC-1:0]                          fail_mask,
  output logic [$clog2(NFUNC*(1<<NVARS)+1)-1:0]     mismatch_count,
  output logic                                      dup_err,
  output logic                                      timeout_err,
  output logic [NFUNC*(1<<NVARS)-1:0]               captured
);

  localparam int ROWS  = 1 << NVARS;
  localparam int TOTAL = NFUNC * ROWS;
  localparam int CW    = $clog2(TOTAL + 1);

  state_t                state_q, state_d;
  logic [ROWS-1:0]       seen_q;
  logic [TT_IDLE_W-1:0]  idle_q;
  logic                  accept, row_new, all_seen, idle_expire;
  logic [TOTAL-1:0]      diff;
  logic [NFUNC-1:0]      fail_d;
  logic [CW-1:0]         count_d;

  assign in_ready    = (state_q == COLLECT);
  assign busy        = (state_q == COLLECT) || (state_q == COMPARE);
  assign done        = (state_q == DONE);
  // start wins over a same-cycle handshake, so the sample is dropped.
  assign accept      = in_valid && in_ready && !start;
  assign row_new     = accept && !seen_q[in_row];
  assign all_seen    = row_new && ((seen_q | (ROWS'(1) << in_row)) == '1);
  assign idle_expire = !accept && (idle_q == TT_IDLE_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output is given a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: if (all_seen || idle_expire) state_d = COMPARE;
        COMPARE: state_d = DONE;
        IDLE, DONE: state_d = state_q;
        default: state_d = IDLE;
      endcase
    end
  end

  // Unseen rows count as mismatching in every function.
  always_comb begin
    diff   = captured ^ EXPECTED;
    fail_d = '0;
    for (int f = 0; f < NFUNC; f++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!seen_q[r]) diff[f*ROWS + r] = 1'b1;
      end
      fail_d[f] = |diff[f*ROWS +: ROWS];
    end
  end

  tt_popcount #(.WIDTH(TOTAL), .CW(CW)) u_popcount (
    .bits  (diff),
    .count (count_d)
  );

  // NOTE: the captured tables are cleared by reset and by start, so a new
  // check never sees stale rows; these are plain flops, not a RAM.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      seen_q         <= '0;
      idle_q         <= '0;
      captured       <= '0;
      dup_err        <= 1'b0;
      timeout_err    <= 1'b0;
      pass           <= 1'b0;
      fail_mask      <= '0;
      mismatch_count <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            idle_q <= '0;
            if (seen_q[in_row]) begin
              dup_err <= 1'b1;
            end else begin
              seen_q[in_row] <= 1'b1;
              for (int f = 0; f < NFUNC; f++) begin
                captured[f*ROWS + int'(in_row)] <= in_funcs[f];
              end
            end
          end else begin
            idle_q <= idle_q + 1'b1;
            if (idle_expire) timeout_err <= 1'b1;
          end
        end
        COMPARE: begin
          fail_mask      <= fail_d;
          mismatch_count <= count_d;
          pass           <= (diff == '0) && !dup_err && !timeout_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed-vector bench for truth_table_checker with hand-computed expectations.
module tb_truth_table_checker;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic        in_ready, busy, done, pass, dup_err, timeout_err;
  logic [2:0]  in_row;
  logic [5:0]  in_funcs, fail_mask, mismatch_count;
  logic [47:0] captured;

  int checks = 0;
  int errors = 0;

  // Row r -> {f5..f0}, hand-derived from 1F,20,04,8A,2A,CE.
  logic [5:0] gold [8] = '{6'b000001, 6'b111001, 6'b100101, 6'b111001,
                           6'b000001, 6'b010010, 6'b100000, 6'b101000};

  localparam logic [47:0] EXP_TABLE = 48'hCE2A8A04201F;

  truth_table_checker dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_row         (in_row),
    .in_funcs       (in_funcs),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_mask      (fail_mask),
    .mismatch_count (mismatch_count),
    .dup_err        (dup_err),
    .timeout_err    (timeout_err),
    .captured       (captured)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] row, input logic [5:0] funcs);
    in_valid = 1'b1;
    in_row   = row;
    in_funcs = funcs;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check(tag, done, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_row = '0; in_funcs = '0;
    step(); step();
    reset = 1'b0;

    // reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", in_ready, 0);
    check("rst_pass", pass, 0);
    check("rst_captured", captured, 0);
    check("rst_errs", {dup_err, timeout_err}, 0);

    // in-order golden rows, exact latency
    pulse_start();
    check("t1_ready", in_ready, 1);
    for (int r = 0; r < 8; r++) send(3'(r), gold[r]);
    check("t1_compare_busy", busy, 1);
    check("t1_compare_done", done, 0);
    step();
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    check("t1_pass", pass, 1);
    check("t1_fail_mask", fail_mask, 0);
    check("t1_count", mismatch_count, 0);
    check("t1_captured", captured, EXP_TABLE);
    step(); step();
    check("t1_hold", {done, pass}, 2'b11);

    // reverse order with 3-cycle gaps
    pulse_start();
    check("t2_cleared", captured, 0);
    for (int r = 7; r >= 0; r--) begin
      send(3'(r), gold[r]);
      if (r != 0) begin step(); step(); step(); end
    end
    step();
    check("t2_done", done, 1);
    check("t2_pass", pass, 1);
    check("t2_timeout", timeout_err, 0);
    check("t2_captured", captured, EXP_TABLE);

    // row 5 with f1 cleared and f3 set
    pulse_start();
    for (int r = 0; r < 8; r++) send(3'(r), (r == 5) ? 6'b011000 : gold[r]);
    wait_done("t3_done", 4);
    check("t3_pass", pass, 0);
    check("t3_fail_mask", fail_mask, 6'b001010);
    check("t3_count", mismatch_count, 2);

    // duplicate row 2 with all-ones data
    pulse_start();
    for (int r = 0; r < 8; r++) begin
      send(3'(r), gold[r]);
      if (r == 2) send(3'd2, 6'b111111);
    end
    wait_done("t4_done", 4);
    check("t4_dup", dup_err, 1);
    check("t4_pass", pass, 0);
    check("t4_fail_mask", fail_mask, 0);
    check("t4_count", mismatch_count, 0);
    check("t4_captured", captured, EXP_TABLE);

    // timeout after rows 0..5
    pulse_start();
    for (int r = 0; r < 6; r++) send(3'(r), gold[r]);
    for (int i = 0; i < 16; i++) step();
    check("t5_not_done_yet", done, 0);
    step();
    check("t5_done", done, 1);
    check("t5_timeout", timeout_err, 1);
    check("t5_pass", pass, 0);
    check("t5_fail_mask", fail_mask, 6'b111111);
    check("t5_count", mismatch_count, 12);

    // restart mid-collection; same-cycle sample must be dropped
    pulse_start();
    for (int r = 0; r < 4; r++) send(3'(r), gold[r]);
    start = 1'b1; in_valid = 1'b1; in_row = 3'd4; in_funcs = 6'b111111;
    step();
    start = 1'b0; in_valid = 1'b0;
    check("t6_cleared", captured, 0);
    check("t6_busy", busy, 1);
    check("t6_errs", {dup_err, timeout_err, done}, 0);
    for (int r = 0; r < 8; r++) send(3'(r), gold[r]);
    wait_done("t6_done", 4);
    check("t6_pass", pass, 1);
    check("t6_dup", dup_err, 0);
    check("t6_captured", captured, EXP_TABLE);

    // reset mid-collection
    pulse_start();
    for (int r = 0; r < 3; r++) send(3'(r), gold[r]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t7_ready", in_ready, 0);
    check("t7_busy_done", {busy, done}, 0);
    check("t7_results", {pass, dup_err, timeout_err, fail_mask, mismatch_count}, 0);
    check("t7_captured", captured, 0);
    send(3'd0, 6'b111111);
    check("t7_idle_ignore", captured, 0);
    check("t7_still_idle", {busy, done}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
